// File: rtl/m_m_game_master.sv
// rtl/m_m_game_master.sv - four-round game session sequencer driving an up/down counter
module m_m_game_master #(
    parameter int TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] seq_val,
    input  logic       gameover,
    input  logic [1:0] who,
    output logic [1:0] ctrl,
    output logic [2:0] initial_val,
    output logic       init,
    output logic       counter_reset,
    output logic       busy,
    output logic       done,
    output logic [1:0] round,
    output logic [2:0] score_w,
    output logic [2:0] score_l,
    output logic [2:0] timeout_cnt,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RST  = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wdog;
    logic [1:0] ctrl_q;
    logic [2:0] ival_q;
    logic [2:0] load_val;
    logic       wd_expire;
    logic       leave_run;

    assign load_val  = seq_val + {1'b0, round};
    assign wd_expire = (wdog == WD_LAST);
    assign leave_run = (state == RUN) && (gameover || wd_expire);

    always_comb begin
        state_nxt     = state;
        init          = 1'b0;
        counter_reset = reset;
        busy          = 1'b0;
        done          = 1'b0;
        ctrl          = ctrl_q;
        initial_val   = ival_q;
        case (state)
            IDLE: if (start) state_nxt = RST;
            RST: begin
                state_nxt     = LOAD;
                counter_reset = 1'b1;
                busy          = 1'b1;
            end
            LOAD: begin
                // Load values are presented combinationally so they are valid with the init strobe.
                state_nxt   = RUN;
                init        = 1'b1;
                busy        = 1'b1;
                ctrl        = round;
                initial_val = load_val;
            end
            RUN: begin
                busy = 1'b1;
                if (leave_run) state_nxt = (round == 2'd3) ? DONE : RST;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = RST;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wdog        <= '0;
            ctrl_q      <= '0;
            ival_q      <= '0;
            round       <= '0;
            score_w     <= '0;
            score_l     <= '0;
            timeout_cnt <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        round       <= '0;
                        score_w     <= '0;
                        score_l     <= '0;
                        timeout_cnt <= '0;
                        err         <= 1'b0;
                    end
                end
                LOAD: begin
                    ctrl_q <= round;
                    ival_q <= load_val;
                    wdog   <= '0;
                end
                RUN: begin
                    wdog <= wdog + 8'd1;
                    // A game result wins over a coincident watchdog expiry.
                    if (gameover) begin
                        case (who)
                            2'b01:   score_w <= score_w + 3'd1;
                            2'b10:   score_l <= score_l + 3'd1;
                            default: err     <= 1'b1;
                        endcase
                    end else if (wd_expire) begin
                        timeout_cnt <= timeout_cnt + 3'd1;
                    end
                    if (leave_run && round != 2'd3) round <= round + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m_m_game_master.sv
// tb/tb_m_m_game_master.sv - scoreboard bench for m_m_game_master
module tb_m_m_game_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] seq_val;
    logic       gameover;
    logic [1:0] who;
    logic [1:0] ctrl;
    logic [2:0] initial_val;
    logic       init;
    logic       counter_reset;
    logic       busy;
    logic       done;
    logic [1:0] round;
    logic [2:0] score_w;
    logic [2:0] score_l;
    logic [2:0] timeout_cnt;
    logic       err;

    int errors = 0;
    int checks = 0;

    logic [4:0] load_q[$];
    logic [9:0] res_q[$];
    logic       done_d = 1'b0;

    m_m_game_master #(.TIMEOUT(200)) dut (
        .clk(clk), .reset(reset), .start(start), .seq_val(seq_val),
        .gameover(gameover), .who(who), .ctrl(ctrl), .initial_val(initial_val),
        .init(init), .counter_reset(counter_reset), .busy(busy), .done(done),
        .round(round), .score_w(score_w), .score_l(score_l),
        .timeout_cnt(timeout_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, got no event expected one", name);
    endtask

    // Monitor: pops expected load pairs on init, expected tallies on done rising.
    always @(negedge clk) begin
        logic [4:0] le;
        logic [9:0] re;
        if (reset) begin
            done_d = 1'b0;
        end else begin
            if (init) begin
                if (load_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL load_unexpected: got init expected none");
                end else begin
                    le = load_q.pop_front();
                    check("load_ctrl", ctrl, le[4:3]);
                    check("load_ival", initial_val, le[2:0]);
                end
            end
            if (done && !done_d) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got done expected none");
                end else begin
                    re = res_q.pop_front();
                    check("res_score_w", score_w, re[9:7]);
                    check("res_score_l", score_l, re[6:4]);
                    check("res_timeout", timeout_cnt, re[3:1]);
                    check("res_err", err, re[0]);
                    check("res_busy", busy, 0);
                end
            end
            done_d = done;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!init && n < 600) begin
            tick();
            n++;
        end
        if (!init) fail_timeout(name);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 600) begin
            tick();
            n++;
        end
        if (!done) fail_timeout(name);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic play_round(input logic [1:0] w, input int delay);
        wait_init("play_init");
        repeat (delay) tick();
        gameover = 1'b1;
        who      = w;
        tick();
        gameover = 1'b0;
        who      = 2'b00;
    endtask

    task automatic timeout_round(input string name);
        int n = 0;
        wait_init("timeout_init");
        tick();
        while (!counter_reset && !done && n < 400) begin
            n++;
            tick();
        end
        check(name, n, 200);
    endtask

    task automatic push_loads(input logic [2:0] base, input int rounds);
        logic [2:0] v;
        for (int r = 0; r < rounds; r++) begin
            v = base + 3'(r);
            load_q.push_back({2'(r), v});
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctrl"}, ctrl, 0);
        check({tag, "_ival"}, initial_val, 0);
        check({tag, "_init"}, init, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_round"}, round, 0);
        check({tag, "_score_w"}, score_w, 0);
        check({tag, "_score_l"}, score_l, 0);
        check({tag, "_timeout"}, timeout_cnt, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b1; gameover = 1'b1; who = 2'b01; seq_val = 3'd7;
        repeat (3) tick();
        check_reset_values("reset");
        check("reset_counter_reset", counter_reset, 1);
        reset = 1'b0; start = 1'b0; gameover = 1'b0; who = 2'b00;
        tick();
        check("idle_counter_reset", counter_reset, 0);

        // Normal session: all winners.
        seq_val = 3'd5;
        push_loads(3'd5, 4);
        res_q.push_back({3'd4, 3'd0, 3'd0, 1'b0});
        pulse_start();
        repeat (4) play_round(2'b01, 20);
        wait_done("a_done");
        check("a_score_w", score_w, 4);

        // All timeouts, restarted from DONE.
        seq_val = 3'd2;
        push_loads(3'd2, 4);
        res_q.push_back({3'd0, 3'd0, 3'd4, 1'b0});
        pulse_start();
        check("b_restart_busy", busy, 1);
        check("b_restart_clear", score_w, 0);
        timeout_round("b_run_len0");
        timeout_round("b_run_len1");
        timeout_round("b_run_len2");
        timeout_round("b_run_len3");
        wait_done("b_done");

        // Gameover coincident with watchdog expiry in round 1.
        seq_val = 3'd0;
        push_loads(3'd0, 4);
        res_q.push_back({3'd3, 3'd1, 3'd0, 1'b0});
        pulse_start();
        play_round(2'b01, 5);
        wait_init("c_init1");
        repeat (200) tick();
        gameover = 1'b1; who = 2'b10;
        tick();
        gameover = 1'b0; who = 2'b00;
        check("c_score_l", score_l, 1);
        check("c_timeout", timeout_cnt, 0);
        check("c_round", round, 2);
        play_round(2'b01, 3);
        play_round(2'b01, 3);
        wait_done("c_done");

        // Invalid code, start during RUN, then mid-run reset.
        seq_val = 3'd3;
        push_loads(3'd3, 3);
        pulse_start();
        wait_init("d_init0");
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("d_start_ignored_round", round, 0);
        check("d_start_ignored_busy", busy, 1);
        gameover = 1'b1; who = 2'b11;
        tick();
        gameover = 1'b0; who = 2'b00;
        check("d_err", err, 1);
        check("d_err_score_w", score_w, 0);
        check("d_err_score_l", score_l, 0);
        check("d_err_round", round, 1);
        play_round(2'b01, 4);
        check("d_err_sticky", err, 1);
        wait_init("d_init2");
        repeat (10) tick();
        reset = 1'b1;
        #1;
        check("d_reset_counter_reset", counter_reset, 1);
        tick();
        check_reset_values("midrst");
        check("midrst_counter_reset", counter_reset, 1);
        reset = 1'b0;
        tick();

        // Replay after reset starts again from round 0.
        push_loads(3'd3, 4);
        res_q.push_back({3'd0, 3'd4, 3'd0, 1'b0});
        pulse_start();
        repeat (4) play_round(2'b10, 2);
        wait_done("e_done");
        repeat (2) tick();

        check("load_q_empty", load_q.size(), 0);
        check("res_q_empty", res_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
